// File: rtl/ptp_ts_capture.sv
// Event timestamp capture: sample RTC on evt_i, add latency correction,
// normalise seconds/nanoseconds, and queue result + tag in a FWFT FIFO.
module ptp_ts_capture #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 2,
  parameter logic [31:0] NS_MAX = 32'd1_000_000_000
) (
  input  logic          rtc_clk,
  input  logic          rtc_rst_n,
  input  logic [79:0]   rtc_std_i,
  input  logic [15:0]   rtc_fns_i,
  input  logic [31:0]   corr_ns_i,
  input  logic          evt_i,
  input  logic [15:0]   evt_tag_i,
  input  logic          fifo_clr_i,
  input  logic          ts_ready_i,
  output logic          ts_valid_o,
  output logic [79:0]   ts_std_o,
  output logic [15:0]   ts_fns_o,
  output logic [15:0]   ts_tag_o,
  output logic [AW:0]   fifo_cnt_o,
  output logic          ovf_o,
  input  logic          ovf_clr_i
);

  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [47:0] sec;
    logic [31:0] ns;
    logic [15:0] fns;
    logic [15:0] tag;
  } ts_entry_t;

  // S1 state: raw sample plus unnormalised nanosecond sum
  logic        s1_vld;
  logic [47:0] s1_sec;
  logic [15:0] s1_fns;
  logic [15:0] s1_tag;
  logic [32:0] s1_sum;

  // S2 state: normalised entry ready to push
  logic      s2_vld;
  ts_entry_t s2_ent;

  // FIFO state
  ts_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic [32:0] ns_wrap;
  logic        carry;
  logic        fifo_full;
  logic        pop;
  logic        push_req;
  logic        push;
  logic        ovf_set;

  assign ns_wrap   = s1_sum - 33'(NS_MAX);
  assign carry     = (s1_sum >= 33'(NS_MAX));
  assign fifo_full = (cnt == CW'(DEPTH));
  assign pop       = (cnt != '0) & ts_ready_i & ~fifo_clr_i;
  assign push_req  = s2_vld & ~fifo_clr_i;
  // A full FIFO still accepts a push when the head is popped on the same edge
  assign push      = push_req & (~fifo_full | pop);
  assign ovf_set   = push_req & fifo_full & ~pop;

  // Stage 1: sample time, tag and correction sum
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      s1_vld <= 1'b0;
      s1_sec <= '0;
      s1_fns <= '0;
      s1_tag <= '0;
      s1_sum <= '0;
    end else begin
      s1_vld <= evt_i & ~fifo_clr_i;
      if (evt_i) begin
        s1_sec <= rtc_std_i[79:32];
        s1_fns <= rtc_fns_i;
        s1_tag <= evt_tag_i;
        s1_sum <= {1'b0, rtc_std_i[31:0]} + {1'b0, corr_ns_i};
      end
    end
  end

  // Stage 2: nanosecond rollover with carry into 48b seconds
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      s2_vld <= 1'b0;
      s2_ent <= '0;
    end else begin
      s2_vld <= s1_vld & ~fifo_clr_i;
      if (s1_vld) begin
        s2_ent.sec <= carry ? (s1_sec + 48'd1) : s1_sec;
        s2_ent.ns  <= carry ? ns_wrap[31:0] : s1_sum[31:0];
        s2_ent.fns <= s1_fns;
        s2_ent.tag <= s1_tag;
      end
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (fifo_clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s2_ent;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky overflow; a new overflow wins over a clear on the same edge
  always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
    if (!rtc_rst_n)     ovf <= 1'b0;
    else if (ovf_set)   ovf <= 1'b1;
    else if (ovf_clr_i) ovf <= 1'b0;
  end

  assign ts_valid_o = (cnt != '0);
  assign ts_std_o   = {mem[rd_ptr].sec, mem[rd_ptr].ns};
  assign ts_fns_o   = mem[rd_ptr].fns;
  assign ts_tag_o   = mem[rd_ptr].tag;
  assign fifo_cnt_o = cnt;
  assign ovf_o      = ovf;

endmodule

// File: tb/tb_ptp_ts_capture.sv
// Directed bench for ptp_ts_capture: normalisation vectors plus FIFO corner sequences.
module tb_ptp_ts_capture;

  logic        rtc_clk = 1'b0;
  logic        rtc_rst_n;
  logic [79:0] rtc_std_i;
  logic [15:0] rtc_fns_i;
  logic [31:0] corr_ns_i;
  logic        evt_i;
  logic [15:0] evt_tag_i;
  logic        fifo_clr_i;
  logic        ts_ready_i;
  logic        ts_valid_o;
  logic [79:0] ts_std_o;
  logic [15:0] ts_fns_o;
  logic [15:0] ts_tag_o;
  logic [2:0]  fifo_cnt_o;
  logic        ovf_o;
  logic        ovf_clr_i;

  int checks = 0;
  int errors = 0;

  always #5 rtc_clk = ~rtc_clk;

  ptp_ts_capture #(.DEPTH(4), .AW(2), .NS_MAX(32'd1_000_000_000)) dut (
    .rtc_clk(rtc_clk), .rtc_rst_n(rtc_rst_n), .rtc_std_i(rtc_std_i),
    .rtc_fns_i(rtc_fns_i), .corr_ns_i(corr_ns_i), .evt_i(evt_i),
    .evt_tag_i(evt_tag_i), .fifo_clr_i(fifo_clr_i), .ts_ready_i(ts_ready_i),
    .ts_valid_o(ts_valid_o), .ts_std_o(ts_std_o), .ts_fns_o(ts_fns_o),
    .ts_tag_o(ts_tag_o), .fifo_cnt_o(fifo_cnt_o), .ovf_o(ovf_o),
    .ovf_clr_i(ovf_clr_i)
  );

  typedef struct {
    logic [47:0] sec;
    logic [31:0] ns;
    logic [15:0] fns;
    logic [31:0] corr;
    logic [15:0] tag;
    logic [47:0] exp_sec;
    logic [31:0] exp_ns;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // advance to just after the next active edge
  task automatic step();
    @(posedge rtc_clk);
    #1;
  endtask

  // issue one event for the following edge, then drop evt_i and scramble corr
  task automatic fire(input logic [47:0] sec, input logic [31:0] ns, input logic [15:0] fns,
                      input logic [31:0] corr, input logic [15:0] tag);
    rtc_std_i = {sec, ns};
    rtc_fns_i = fns;
    corr_ns_i = corr;
    evt_tag_i = tag;
    evt_i     = 1'b1;
    step();
    evt_i     = 1'b0;
    corr_ns_i = 32'd12345;
  endtask

  task automatic pop_one();
    ts_ready_i = 1'b1;
    step();
    ts_ready_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{48'd5, 32'd100, 16'hA001, 32'd40, 16'd101, 48'd5, 32'd140};
    vecs[1] = '{48'd7, 32'd999_999_990, 16'hA002, 32'd20, 16'd102, 48'd8, 32'd10};
    vecs[2] = '{48'hFFFF_FFFF_FFFF, 32'd999_999_999, 16'hA003, 32'd1, 16'd103, 48'd0, 32'd0};
    vecs[3] = '{48'd3, 32'd999_999_979, 16'hA004, 32'd20, 16'd104, 48'd3, 32'd999_999_999};
    vecs[4] = '{48'd10, 32'd0, 16'hA005, 32'd999_999_999, 16'd105, 48'd10, 32'd999_999_999};
    vecs[5] = '{48'd20, 32'd999_999_999, 16'hA006, 32'd999_999_999, 16'd106, 48'd21, 32'd999_999_998};

    rtc_rst_n = 1'b0; rtc_std_i = '0; rtc_fns_i = '0; corr_ns_i = '0; evt_i = 1'b0;
    evt_tag_i = '0; fifo_clr_i = 1'b0; ts_ready_i = 1'b0; ovf_clr_i = 1'b0;
    repeat (2) step();
    rtc_rst_n = 1'b1;
    step();
    check("rst_valid", 80'(ts_valid_o), 80'(0));
    check("rst_cnt", 80'(fifo_cnt_o), 80'(0));
    check("rst_ovf", 80'(ovf_o), 80'(0));
    check("rst_std", ts_std_o, 80'(0));

    // normalisation vectors: one event each, 2-cycle latency, then pop
    for (int i = 0; i < 6; i++) begin
      fire(vecs[i].sec, vecs[i].ns, vecs[i].fns, vecs[i].corr, vecs[i].tag);
      check("lat_k1_valid", 80'(ts_valid_o), 80'(0));
      step();
      check("lat_k2_valid", 80'(ts_valid_o), 80'(0));
      step();
      check("vec_valid", 80'(ts_valid_o), 80'(1));
      check("vec_std", ts_std_o, {vecs[i].exp_sec, vecs[i].exp_ns});
      check("vec_fns", 80'(ts_fns_o), 80'(vecs[i].fns));
      check("vec_tag", 80'(ts_tag_o), 80'(vecs[i].tag));
      pop_one();
      check("vec_cnt_after_pop", 80'(fifo_cnt_o), 80'(0));
    end

    // overflow: five back-to-back events into a 4-deep FIFO
    for (int t = 1; t <= 5; t++) fire(48'd1, 32'(t), 16'(t), 32'd0, 16'(t));
    repeat (3) step();
    check("ovf_cnt", 80'(fifo_cnt_o), 80'(4));
    check("ovf_flag", 80'(ovf_o), 80'(1));
    for (int t = 1; t <= 4; t++) begin
      check("drain_tag", 80'(ts_tag_o), 80'(t));
      pop_one();
    end
    check("drain_empty", 80'(ts_valid_o), 80'(0));
    check("ovf_sticky", 80'(ovf_o), 80'(1));
    ovf_clr_i = 1'b1; step(); ovf_clr_i = 1'b0;
    check("ovf_cleared", 80'(ovf_o), 80'(0));

    // full FIFO with push and pop on the same edge
    for (int t = 11; t <= 14; t++) fire(48'd2, 32'd0, 16'd0, 32'd0, 16'(t));
    repeat (2) step();
    check("full_cnt", 80'(fifo_cnt_o), 80'(4));
    fire(48'd2, 32'd0, 16'd0, 32'd0, 16'd15);
    step();
    ts_ready_i = 1'b1;
    step();
    ts_ready_i = 1'b0;
    check("pp_cnt", 80'(fifo_cnt_o), 80'(4));
    check("pp_ovf", 80'(ovf_o), 80'(0));
    for (int t = 12; t <= 15; t++) begin
      check("pp_tag", 80'(ts_tag_o), 80'(t));
      pop_one();
    end
    check("pp_empty", 80'(fifo_cnt_o), 80'(0));

    // flush with two events in flight and one event coincident with the flush
    fire(48'd3, 32'd0, 16'd0, 32'd0, 16'd21);
    fire(48'd3, 32'd0, 16'd0, 32'd0, 16'd22);
    evt_tag_i = 16'd23; evt_i = 1'b1; fifo_clr_i = 1'b1;
    step();
    evt_i = 1'b0; fifo_clr_i = 1'b0;
    check("clr_cnt", 80'(fifo_cnt_o), 80'(0));
    check("clr_valid", 80'(ts_valid_o), 80'(0));
    for (int c = 0; c < 4; c++) begin
      check("clr_stays_empty", 80'(ts_valid_o), 80'(0));
      step();
    end

    // async reset mid-stream with data queued and overflow set
    for (int t = 31; t <= 35; t++) fire(48'd4, 32'd7, 16'h55, 32'd0, 16'(t));
    repeat (3) step();
    check("pre_rst_ovf", 80'(ovf_o), 80'(1));
    fire(48'd4, 32'd7, 16'h55, 32'd0, 16'd36);
    #2 rtc_rst_n = 1'b0;
    #1;
    check("arst_valid", 80'(ts_valid_o), 80'(0));
    check("arst_cnt", 80'(fifo_cnt_o), 80'(0));
    check("arst_ovf", 80'(ovf_o), 80'(0));
    check("arst_std", ts_std_o, 80'(0));
    check("arst_tag", 80'(ts_tag_o), 80'(0));
    check("arst_fns", 80'(ts_fns_o), 80'(0));
    step();
    rtc_rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_dropped", 80'(ts_valid_o), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
